noc_router: RTL and testbench
=============================

# noc_router

Wormhole packet router between the processing units' data-memory send/receive ports. Each PU's transmit stream (HEAD, BODY…, TAIL flits, one per cycle, no backpressure) enters an input FIFO. The HEAD's destination field selects an output, which is locked to that input until the TAIL passes. Each output drives the receiving PU's flit input. Contention for an output is resolved round-robin per output.

## Interface
- `NP`, default 4: number of ports (PUs); port index width is `PORT`+1 bits.
- `DEPTH`, default 8: flits per input FIFO, power of two ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_flit`  in  NP×(`PKTW`+1)  flit from PU i's transmit stream; all-zero = idle.
- `out_flit`  out  NP×(`PKTW`+1)  flit to PU j's receive input; registered; all-zero = idle.
- `overflow`  out  NP  sticky: a non-idle flit arrived on input i while its FIFO was full and no pop occurred.
- `proto_err`  out  NP  sticky: input i's FIFO head was BODY/TAIL with no output locked to i.

## Operation
- Flit type is `in_flit[`FLOWBH:`FLOWBL]`: `HEAD`, `BODY`, `TAIL`; type 0 = idle, never stored.
- HEAD destination = low `PORT`+1 bits of the payload. Other payload bits are ignored for routing and forwarded unchanged.
- Input side, per i:
  - push a non-idle `in_flit[i]` every cycle.
  - full with no same-cycle pop: drop the flit and set `overflow[i]`.
  - full with a same-cycle pop: accept the flit.
- Output side, per j. States: IDLE and LOCKED(owner).
  - IDLE, candidates: inputs whose FIFO head is a HEAD with dest = j and which are not currently owner of any output.
  - IDLE, arbitration: grant the first candidate at or after `rr_ptr[j]`, wrapping modulo NP.
  - IDLE, on grant: pop the HEAD, drive it on `out_flit[j]`, go to LOCKED(owner).
  - IDLE, no candidate: drive 0.
  - LOCKED, owner FIFO non-empty: pop the head and drive it. A HEAD at the head is forwarded as an ordinary payload flit and the lock is kept.
  - LOCKED, flit is a TAIL: go to IDLE and set `rr_ptr[j]` = owner+1 mod NP.
  - LOCKED, owner FIFO empty (source bubble): drive 0 and stay LOCKED.
- Inputs whose FIFO head is BODY/TAIL and which own no output: pop and discard one flit per cycle, set `proto_err[i]`.
- An input pops at most once per cycle. It can own at most one output and can be a candidate for only one output (its head's dest), so there is no double pop.
- Self-route (dest = own index) is legal.
- HEAD/TAIL are forwarded; the receiving PU counts only BODY flits.
- Sticky flags clear only on reset.

## Timing
- Reset (async, `rst_n` low):
  - `out_flit` = 0, `overflow` = 0, `proto_err` = 0.
  - All FIFOs empty, all outputs IDLE, `rr_ptr` = 0.
  - Reset mid-packet discards all buffered flits. The receiver sees the stream truncated with no TAIL.
- Latency with no contention: flit sampled on `in_flit` at edge k is on `out_flit` after edge k+1. Two-cycle pipe: FIFO write, then registered output.
- Throughput: one flit per cycle per locked output. A back-to-back source stream passes with no bubbles.
- A granted HEAD and its following BODY leave on consecutive cycles if already buffered. TAIL→IDLE→new HEAD costs no extra cycle: arbitration happens in the cycle after the TAIL is driven.
- The FIFO's pop, in-cycle, frees space for a same-cycle push when full. It never reads a flit written that same edge: no bypass, the head is visible one cycle after the write.

## Structure
- Shared package (`pu/pu.vh` side): `PKTW`, `FLOWBH`/`FLOWBL`, `HEAD`/`BODY`/`TAIL` codes, `PORT`, and the output-state enum {IDLE, LOCKED}.
- Sub-module `flit_fifo`:
  - Ports: clk, rst_n, push/din, pop/dout, empty, full.
  - Implementation: DEPTH entries, read/write pointers with wrap bit, async reset of the pointers only.
- Router top: NP `flit_fifo` instances, per-output lock/owner/rr_ptr registers, combinational candidate/grant logic, registered outputs.

## Test plan
- Single packet 0→2: HEAD(dest 2), BODY 0x11, BODY 0x22, TAIL on consecutive cycles -> `out_flit[2]` shows the same four flits starting 2 cycles later, no gaps. Other outputs stay 0.
- Contention: PU1 and PU3 both send HEAD dest 0 in the same cycle, 3 BODYs each, `rr_ptr[0]`=0 -> PU1's packet goes out first, PU3's HEAD follows on the cycle after PU1's TAIL. Then `rr_ptr[0]`=0 after PU3's TAIL (3+1 mod 4).
- Parallel routes: 0→1 and 2→3 simultaneously -> both outputs stream with 2-cycle latency, no interference.
- Overflow: DEPTH=8, PU0 sends HEAD dest 1 while output 1 is locked by PU2's long packet; PU0 sends 10 flits -> 8 buffered, `overflow[0]`=1. The first 8 PU0 flits are delivered after PU2's TAIL.
- Protocol error: BODY 0x55 on input 3 with no prior HEAD -> flit discarded, `proto_err[3]`=1, all `out_flit` stay 0.
- Reset mid-packet: assert `rst_n` low during BODY 2 of a 0→2 packet -> `out_flit`=0 immediately. After release, a new packet 0→2 routes normally with `rr_ptr` back at 0.

Source files
------------

// File: rtl/noc_router_pkg.sv
// Shared flit format, port index width and output-state encoding
// for the wormhole NoC router.
package noc_router_pkg;

    localparam int PKTW   = 17;
    localparam int FLOWBH = 17;
    localparam int FLOWBL = 16;
    localparam int PORT   = 1;

    localparam logic [1:0] IDLE_F = 2'd0;
    localparam logic [1:0] HEAD   = 2'd1;
    localparam logic [1:0] BODY   = 2'd2;
    localparam logic [1:0] TAIL   = 2'd3;

    typedef logic [PKTW:0] flit_t;
    typedef logic [PORT:0] port_t;

    typedef enum logic {IDLE, LOCKED} ostate_t;

    function automatic logic [1:0] flit_type(input flit_t f);
        return f[FLOWBH:FLOWBL];
    endfunction

    function automatic port_t flit_dest(input flit_t f);
        return f[PORT:0];
    endfunction

endpackage

// File: rtl/noc_router_fifo.sv
// Per-input flit buffer: DEPTH entries, wrap-bit pointers, no bypass.
// Only the pointers are reset; storage contents are don't-care.
module flit_fifo
    import noc_router_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  flit_t din,
    input  logic  pop,
    output flit_t dout,
    output logic  empty,
    output logic  full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    flit_t       mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + ONE;
            if (pop)  rptr <= rptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/noc_router.sv
// Wormhole router: per-input FIFOs, per-output lock with round-robin
// arbitration among HEADs, registered flit outputs and sticky error flags.
module noc_router
    import noc_router_pkg::*;
#(
    parameter int NP    = 4,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NP-1:0][PKTW:0] in_flit,
    output logic [NP-1:0][PKTW:0] out_flit,
    output logic [NP-1:0]        overflow,
    output logic [NP-1:0]        proto_err
);

    flit_t   head   [NP];
    logic [NP-1:0] empty;
    logic [NP-1:0] full;
    logic [NP-1:0] push;
    logic [NP-1:0] pop;
    logic [NP-1:0] drop;
    logic [NP-1:0] perr;
    logic [NP-1:0] owns;

    ostate_t state  [NP];
    port_t   owner  [NP];
    port_t   rr_ptr [NP];

    ostate_t nxt_state [NP];
    port_t   nxt_owner [NP];
    port_t   nxt_rr    [NP];
    logic [NP-1:0][PKTW:0] nxt_out;

    for (genvar i = 0; i < NP; i++) begin : g_fifo
        flit_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .din   (in_flit[i]),
            .pop   (pop[i]),
            .dout  (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    // A full FIFO still accepts when its head leaves in the same cycle.
    always_comb begin
        push = '0;
        drop = '0;
        for (int i = 0; i < NP; i++) begin
            push[i] = (flit_type(in_flit[i]) != IDLE_F) &&
                      (!full[i] || pop[i]);
            drop[i] = (flit_type(in_flit[i]) != IDLE_F) &&
                      full[i] && !pop[i];
        end
    end

    always_comb begin
        int   c;
        logic found;
        c         = 0;
        found     = 1'b0;
        pop       = '0;
        perr      = '0;
        owns      = '0;
        nxt_out   = '0;
        nxt_state = state;
        nxt_owner = owner;
        nxt_rr    = rr_ptr;

        for (int j = 0; j < NP; j++) begin
            if (state[j] == LOCKED) owns[owner[j]] = 1'b1;
        end

        for (int j = 0; j < NP; j++) begin
            if (state[j] == LOCKED) begin
                if (!empty[owner[j]]) begin
                    pop[owner[j]] = 1'b1;
                    nxt_out[j]    = head[owner[j]];
                    if (flit_type(head[owner[j]]) == TAIL) begin
                        nxt_state[j] = IDLE;
                        nxt_rr[j]    = (owner[j] == port_t'(NP - 1)) ?
                                       '0 : port_t'(owner[j] + 1'b1);
                    end
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < NP; k++) begin
                    c = (int'(rr_ptr[j]) + k) % NP;
                    if (!found && !empty[c] && !owns[c] &&
                        flit_type(head[c]) == HEAD &&
                        flit_dest(head[c]) == port_t'(j)) begin
                        found        = 1'b1;
                        pop[c]       = 1'b1;
                        nxt_out[j]   = head[c];
                        nxt_state[j] = LOCKED;
                        nxt_owner[j] = port_t'(c);
                    end
                end
            end
        end

        // Orphan BODY/TAIL flits are flushed one per cycle.
        for (int i = 0; i < NP; i++) begin
            if (!empty[i] && !owns[i] &&
                (flit_type(head[i]) == BODY ||
                 flit_type(head[i]) == TAIL)) begin
                pop[i]  = 1'b1;
                perr[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flit  <= '0;
            overflow  <= '0;
            proto_err <= '0;
            for (int j = 0; j < NP; j++) begin
                state[j]  <= IDLE;
                owner[j]  <= '0;
                rr_ptr[j] <= '0;
            end
        end else begin
            out_flit  <= nxt_out;
            overflow  <= overflow | drop;
            proto_err <= proto_err | perr;
            state     <= nxt_state;
            owner     <= nxt_owner;
            rr_ptr    <= nxt_rr;
        end
    end

endmodule

// File: tb/tb_noc_router.sv
// Directed bench for noc_router: latency, round-robin, parallel routes,
// overflow, orphan flits and mid-packet reset.
module tb_noc_router;
    import noc_router_pkg::*;

    logic                clk;
    logic                rst_n;
    logic [3:0][PKTW:0]  in_flit;
    logic [3:0][PKTW:0]  out_flit;
    logic [3:0]          overflow;
    logic [3:0]          proto_err;

    int n_assert = 0;
    int n_fail   = 0;

    noc_router #(.NP(4), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (in_flit),
        .out_flit  (out_flit),
        .overflow  (overflow),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk(input logic [1:0] t, input logic [15:0] p);
        return {t, p};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input flit_t e0, input flit_t e1,
                           input flit_t e2, input flit_t e3);
        chk($sformatf("%s out0", tag), 32'(out_flit[0]), 32'(e0));
        chk($sformatf("%s out1", tag), 32'(out_flit[1]), 32'(e1));
        chk($sformatf("%s out2", tag), 32'(out_flit[2]), 32'(e2));
        chk($sformatf("%s out3", tag), 32'(out_flit[3]), 32'(e3));
    endtask

    flit_t s1 [5];
    flit_t s3 [5];
    flit_t e0 [11];

    initial begin
        rst_n   = 1'b0;
        in_flit = '0;
        tick();
        tick();
        chk_out("reset", '0, '0, '0, '0);
        chk("reset ovf", 32'(overflow), 32'h0);
        chk("reset perr", 32'(proto_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // single packet 0 -> 2
        in_flit[0] = mk(HEAD, 16'h0002);
        tick();
        chk_out("p1 t1", '0, '0, '0, '0);
        in_flit[0] = mk(BODY, 16'h0011);
        tick();
        chk_out("p1 t2", '0, '0, mk(HEAD, 16'h0002), '0);
        in_flit[0] = mk(BODY, 16'h0022);
        tick();
        chk_out("p1 t3", '0, '0, mk(BODY, 16'h0011), '0);
        in_flit[0] = mk(TAIL, 16'h0099);
        tick();
        chk_out("p1 t4", '0, '0, mk(BODY, 16'h0022), '0);
        in_flit[0] = '0;
        tick();
        chk_out("p1 t5", '0, '0, mk(TAIL, 16'h0099), '0);
        tick();
        chk_out("p1 t6", '0, '0, '0, '0);

        // rr_ptr[2] is now 1: input 1 beats input 0
        in_flit[0] = mk(HEAD, 16'h00A2);
        in_flit[1] = mk(HEAD, 16'h00B2);
        tick();
        in_flit[0] = mk(TAIL, 16'h00AF);
        in_flit[1] = mk(TAIL, 16'h00BF);
        tick();
        chk("rr2 t2", 32'(out_flit[2]), 32'(mk(HEAD, 16'h00B2)));
        in_flit[0] = '0;
        in_flit[1] = '0;
        tick();
        chk("rr2 t3", 32'(out_flit[2]), 32'(mk(TAIL, 16'h00BF)));
        tick();
        chk("rr2 t4", 32'(out_flit[2]), 32'(mk(HEAD, 16'h00A2)));
        tick();
        chk("rr2 t5", 32'(out_flit[2]), 32'(mk(TAIL, 16'h00AF)));
        tick();
        chk("rr2 t6", 32'(out_flit[2]), 32'h0);

        // contention 1,3 -> 0
        s1 = '{mk(HEAD, 16'h0100), mk(BODY, 16'h0111), mk(BODY, 16'h0112),
               mk(BODY, 16'h0113), mk(TAIL, 16'h01FF)};
        s3 = '{mk(HEAD, 16'h0300), mk(BODY, 16'h0311), mk(BODY, 16'h0312),
               mk(BODY, 16'h0313), mk(TAIL, 16'h03FF)};
        e0 = '{s1[0], s1[1], s1[2], s1[3], s1[4],
               s3[0], s3[1], s3[2], s3[3], s3[4], '0};
        for (int t = 0; t < 12; t++) begin
            in_flit[1] = (t < 5) ? s1[t] : '0;
            in_flit[3] = (t < 5) ? s3[t] : '0;
            tick();
            if (t >= 1)
                chk($sformatf("cont t%0d", t + 1), 32'(out_flit[0]),
                    32'(e0[t-1]));
        end

        // rr_ptr[0] back to 0: input 1 wins again
        in_flit[1] = mk(HEAD, 16'h0120);
        in_flit[3] = mk(HEAD, 16'h0320);
        tick();
        in_flit[1] = mk(TAIL, 16'h012F);
        in_flit[3] = mk(TAIL, 16'h032F);
        tick();
        chk("rr0 t2", 32'(out_flit[0]), 32'(mk(HEAD, 16'h0120)));
        in_flit[1] = '0;
        in_flit[3] = '0;
        tick();
        chk("rr0 t3", 32'(out_flit[0]), 32'(mk(TAIL, 16'h012F)));
        tick();
        chk("rr0 t4", 32'(out_flit[0]), 32'(mk(HEAD, 16'h0320)));
        tick();
        chk("rr0 t5", 32'(out_flit[0]), 32'(mk(TAIL, 16'h032F)));
        tick();

        // parallel 0 -> 1 and 2 -> 3
        in_flit[0] = mk(HEAD, 16'h0001);
        in_flit[2] = mk(HEAD, 16'h0003);
        tick();
        in_flit[0] = mk(BODY, 16'h0A0A);
        in_flit[2] = mk(BODY, 16'h0B0B);
        tick();
        chk_out("par t2", '0, mk(HEAD, 16'h0001), '0, mk(HEAD, 16'h0003));
        in_flit[0] = mk(TAIL, 16'h0A0F);
        in_flit[2] = mk(TAIL, 16'h0B0F);
        tick();
        chk_out("par t3", '0, mk(BODY, 16'h0A0A), '0, mk(BODY, 16'h0B0B));
        in_flit[0] = '0;
        in_flit[2] = '0;
        tick();
        chk_out("par t4", '0, mk(TAIL, 16'h0A0F), '0, mk(TAIL, 16'h0B0F));
        tick();
        chk_out("par t5", '0, '0, '0, '0);

        // overflow: PU2 holds output 1 while PU0 sends 10 flits
        in_flit[2] = mk(HEAD, 16'h2001);
        tick();
        for (int k = 0; k < 10; k++) begin
            in_flit[2] = mk(BODY, 16'(16'h2010 + k));
            in_flit[0] = (k == 0) ? mk(HEAD, 16'h0101) :
                                    mk(BODY, 16'(16'h0100 + k));
            tick();
            chk($sformatf("ovf out1 k%0d", k), 32'(out_flit[1]),
                (k == 0) ? 32'(mk(HEAD, 16'h2001)) :
                           32'(mk(BODY, 16'(16'h2010 + k - 1))));
            chk($sformatf("ovf flag k%0d", k), 32'(overflow[0]),
                (k >= 8) ? 32'h1 : 32'h0);
        end
        in_flit[0] = '0;
        in_flit[2] = mk(TAIL, 16'h20FF);
        tick();
        chk("ovf last body", 32'(out_flit[1]), 32'(mk(BODY, 16'h2019)));
        in_flit[2] = '0;
        tick();
        chk("ovf pu2 tail", 32'(out_flit[1]), 32'(mk(TAIL, 16'h20FF)));
        tick();
        chk("ovf pu0 head", 32'(out_flit[1]), 32'(mk(HEAD, 16'h0101)));
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("ovf pu0 b%0d", k), 32'(out_flit[1]),
                32'(mk(BODY, 16'(16'h0100 + k))));
        end
        tick();
        chk("ovf bubble", 32'(out_flit[1]), 32'h0);
        in_flit[0] = mk(TAIL, 16'h01FF);
        tick();
        in_flit[0] = '0;
        tick();
        chk("ovf pu0 tail", 32'(out_flit[1]), 32'(mk(TAIL, 16'h01FF)));
        tick();
        chk_out("ovf idle", '0, '0, '0, '0);
        chk("ovf sticky", 32'(overflow), 32'h1);

        // orphan BODY on input 3
        in_flit[3] = mk(BODY, 16'h0055);
        tick();
        chk("perr before", 32'(proto_err), 32'h0);
        in_flit[3] = '0;
        tick();
        chk("perr set", 32'(proto_err), 32'h8);
        chk_out("perr t2", '0, '0, '0, '0);
        tick();
        chk_out("perr t3", '0, '0, '0, '0);

        // reset in the middle of a 0 -> 2 packet
        in_flit[0] = mk(HEAD, 16'h0002);
        tick();
        in_flit[0] = mk(BODY, 16'h0031);
        tick();
        chk("rst pre h", 32'(out_flit[2]), 32'(mk(HEAD, 16'h0002)));
        in_flit[0] = mk(BODY, 16'h0032);
        tick();
        chk("rst pre b1", 32'(out_flit[2]), 32'(mk(BODY, 16'h0031)));
        rst_n      = 1'b0;
        in_flit[0] = '0;
        #1;
        chk_out("rst async", '0, '0, '0, '0);
        chk("rst ovf", 32'(overflow), 32'h0);
        chk("rst perr", 32'(proto_err), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // rr_ptr[2] is 0 again: input 0 beats input 1
        in_flit[0] = mk(HEAD, 16'h0042);
        in_flit[1] = mk(HEAD, 16'h1002);
        tick();
        in_flit[0] = mk(TAIL, 16'h004F);
        in_flit[1] = mk(TAIL, 16'h100F);
        tick();
        chk_out("post t2", '0, '0, mk(HEAD, 16'h0042), '0);
        in_flit[0] = '0;
        in_flit[1] = '0;
        tick();
        chk("post t3", 32'(out_flit[2]), 32'(mk(TAIL, 16'h004F)));
        tick();
        chk("post t4", 32'(out_flit[2]), 32'(mk(HEAD, 16'h1002)));
        tick();
        chk("post t5", 32'(out_flit[2]), 32'(mk(TAIL, 16'h100F)));
        tick();
        chk_out("post t6", '0, '0, '0, '0);
        chk("post perr", 32'(proto_err), 32'h0);
        chk("post ovf", 32'(overflow), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
